y86_stage_sequencer: RTL and testbench

//  Multi-cycle control FSM for the sequential Y86-64 core. Steps one instruction through

---
 rtl/y86_stage_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_y86_stage_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_stage_sequencer.sv
// y86_stage_sequencer: multi-cycle control FSM for the sequential Y86-64 core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB/PCUPD, issuing one-cycle
// stage strobes, handshakes with data RAM (with timeout), and owns status and the
// retired-instruction count.
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds `step` input and a PAUSE state
// after every PCUPD).
module y86_stage_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             instr_valid,
    input  logic             mem_ack,
    input  logic             dmem_error,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_req,
    output logic             wb_en,
    output logic             pc_we,
    output logic [2:0]       stat,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_PCUPD,
        S_HALT
`ifdef SEQ_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        stat_q, stat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic fetch_q, decode_q, exec_q, mem_q, wb_q, pcwe_q, halted_q, busy_q;
    logic is_mem_c;

    // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq
    always_comb begin
        is_mem_c = 1'b0;
        case (icode)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_c = 1'b1;
            default:                            is_mem_c = 1'b0;
        endcase
    end

    // Next-state, status, memory wait counter and retire counter
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_error) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else if (icode == 4'h0) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_mem_c) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (dmem_error) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: state_d = S_PCUPD;
            S_PCUPD: begin
                cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
                state_d = S_PAUSE;
`else
                state_d = S_FETCH;
`endif
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) state_d = S_FETCH;
            end
`endif
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State, status and counters; outputs registered from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            stat_q   <= STAT_AOK;
            wait_q   <= '0;
            cnt_q    <= '0;
            fetch_q  <= 1'b0;
            decode_q <= 1'b0;
            exec_q   <= 1'b0;
            mem_q    <= 1'b0;
            wb_q     <= 1'b0;
            pcwe_q   <= 1'b0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stat_q   <= stat_d;
            wait_q   <= wait_d;
            cnt_q    <= cnt_d;
            fetch_q  <= (state_d == S_FETCH);
            decode_q <= (state_d == S_DECODE);
            exec_q   <= (state_d == S_EXEC);
            mem_q    <= (state_d == S_MEM);
            wb_q     <= (state_d == S_WB);
            pcwe_q   <= (state_d == S_PCUPD);
            halted_q <= (state_d == S_HALT);
            busy_q   <= (state_d != S_IDLE) && (state_d != S_HALT);
        end
    end

    assign fetch_en    = fetch_q;
    assign decode_en   = decode_q;
    assign exec_en     = exec_q;
    assign mem_req     = mem_q;
    assign wb_en       = wb_q;
    assign pc_we       = pcwe_q;
    assign stat        = stat_q;
    assign halted      = halted_q;
    assign busy        = busy_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Bench for y86_stage_sequencer: per-instruction expected stage sequences built
// from the stage rules, with randomized instruction mix and memory ack timing.
module tb_y86_stage_sequencer;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MEM_TIMEOUT = 16;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [3:0]       icode;
    logic             imem_error;
    logic             instr_valid;
    logic             mem_ack;
    logic             dmem_error;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step;
`endif
    logic             fetch_en, decode_en, exec_en, mem_req, wb_en, pc_we;
    logic [2:0]       stat;
    logic             halted, busy;
    logic [CNT_W-1:0] instr_count;

    int errors = 0;
    int checks = 0;
    int exp_stat = 1;
    int exp_count = 0;

    y86_stage_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .imem_error(imem_error), .instr_valid(instr_valid),
        .mem_ack(mem_ack), .dmem_error(dmem_error),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .mem_req(mem_req), .wb_en(wb_en), .pc_we(pc_we), .stat(stat),
        .halted(halted), .busy(busy), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed stage letter from the output pins; X for any illegal combination
    function automatic string obs();
        int n;
        n = int'(fetch_en) + int'(decode_en) + int'(exec_en) + int'(mem_req)
          + int'(wb_en) + int'(pc_we) + int'(halted);
        if (n > 1) return "X";
        if (halted) return busy ? "X" : "H";
        if (fetch_en)  return busy ? "F" : "X";
        if (decode_en) return busy ? "D" : "X";
        if (exec_en)   return busy ? "E" : "X";
        if (mem_req)   return busy ? "M" : "X";
        if (wb_en)     return busy ? "W" : "X";
        if (pc_we)     return busy ? "P" : "X";
        return busy ? "S" : "I";
    endfunction

    function automatic bit is_mem_op(input logic [3:0] ic);
        logic [3:0] ops [6];
        ops = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        foreach (ops[i]) if (ops[i] == ic) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; icode = 4'h1; imem_error = 1'b0;
        instr_valid = 1'b1; mem_ack = 1'b0; dmem_error = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        exp_stat = 1;
        exp_count = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drive one instruction from FETCH; returns with DUT in next FETCH or HALT
    task automatic run_instr(input logic [3:0] ic, input bit valid, input bit ierr,
                             input int ack_at, input bit derr);
        checks++;
        if (obs() != "F") begin
            errors++; $display("FAIL fetch_stage ic=%h: got %s want F", ic, obs());
        end
        icode = ic; instr_valid = valid; imem_error = ierr;
        tick();
        imem_error = 1'b0; instr_valid = 1'b1;
        if (ierr || !valid || ic == 4'h0) begin
            exp_stat = ierr ? 3 : (!valid ? 4 : 2);
            checks++;
            if (obs() != "H" || stat !== 3'(exp_stat)) begin
                errors++; $display("FAIL fetch_fault: got %s stat=%0d want H stat=%0d", obs(), stat, exp_stat);
            end
            return;
        end
        checks++;
        if (obs() != "D") begin
            errors++; $display("FAIL decode_stage ic=%h: got %s want D", ic, obs());
        end
        start = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        checks++;
        if (obs() != "E") begin
            errors++; $display("FAIL exec_stage ic=%h: got %s want E", ic, obs());
        end
        tick();
        if (is_mem_op(ic)) begin
            for (int k = 1; k <= int'(MEM_TIMEOUT); k++) begin
                checks++;
                if (obs() != "M") begin
                    errors++; $display("FAIL mem_stage ic=%h cyc=%0d: got %s want M", ic, k, obs());
                end
                mem_ack = (k == ack_at);
                dmem_error = derr && (k == ack_at);
                tick();
                mem_ack = 1'b0; dmem_error = 1'b0;
                if (k == ack_at && !derr) break;
                if (k == ack_at || k == int'(MEM_TIMEOUT)) begin
                    exp_stat = 3;
                    checks++;
                    if (obs() != "H" || stat !== 3'(exp_stat) || pc_we !== 1'b0) begin
                        errors++; $display("FAIL mem_fault: got %s stat=%0d want H stat=3", obs(), stat);
                    end
                    return;
                end
            end
        end
        checks++;
        if (obs() != "W") begin
            errors++; $display("FAIL wb_stage ic=%h: got %s want W", ic, obs());
        end
        tick();
        checks++;
        if (obs() != "P") begin
            errors++; $display("FAIL pcupd_stage ic=%h: got %s want P", ic, obs());
        end
        tick();
        exp_count = (exp_count < CNT_MAX) ? exp_count + 1 : CNT_MAX;
`ifdef SEQ_SINGLE_STEP_EN
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs() != "S") begin
                errors++; $display("FAIL pause_stage: got %s want S", obs());
            end
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
`endif
        checks++;
        if (instr_count !== CNT_W'(exp_count) || stat !== 3'd1) begin
            errors++; $display("FAIL retire_count: got cnt=%0d stat=%0d want cnt=%0d stat=1", instr_count, stat, exp_count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs() != "I" || stat !== 3'd1 || instr_count !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_state: got %s stat=%0d cnt=%0d busy=%0b want I 1 0 0", obs(), stat, instr_count, busy);
        end
        tick();
        checks++;
        if (obs() != "I") begin
            errors++; $display("FAIL idle_hold: got %s want I", obs());
        end
    endtask

    task automatic test_irmovq();
        do_reset();
        do_start();
        run_instr(4'h3, 1'b1, 1'b0, 0, 1'b0);
        run_instr(4'h3, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_mem_ack3();
        do_reset();
        do_start();
        run_instr(4'h5, 1'b1, 1'b0, 3, 1'b0);
        run_instr(4'h4, 1'b1, 1'b0, int'(MEM_TIMEOUT), 1'b0);
        run_instr(4'h9, 1'b1, 1'b0, 1, 1'b0);
    endtask

    task automatic test_timeout();
        do_reset();
        do_start();
        run_instr(4'h6, 1'b1, 1'b0, 0, 1'b0);
        run_instr(4'hA, 1'b1, 1'b0, 0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (obs() != "H" || stat !== 3'd3 || instr_count !== CNT_W'(exp_count)) begin
            errors++; $display("FAIL halt_sticky: got %s stat=%0d cnt=%0d want H 3 %0d", obs(), stat, instr_count, exp_count);
        end
    endtask

    task automatic test_faults();
        do_reset(); do_start();
        run_instr(4'h2, 1'b0, 1'b0, 0, 1'b0);
        do_reset(); do_start();
        run_instr(4'h2, 1'b0, 1'b1, 0, 1'b0);
        do_reset(); do_start();
        run_instr(4'h8, 1'b1, 1'b0, 2, 1'b1);
    endtask

    task automatic test_halt();
        do_reset(); do_start();
        run_instr(4'h1, 1'b1, 1'b0, 0, 1'b0);
        run_instr(4'h0, 1'b1, 1'b0, 0, 1'b0);
        checks++;
        if (halted !== 1'b1 || instr_count !== CNT_W'(1)) begin
            errors++; $display("FAIL halt_count: got halted=%0b cnt=%0d want 1 1", halted, instr_count);
        end
    endtask

    task automatic test_rst_mid_mem();
        do_reset(); do_start();
        icode = 4'h4;
        tick(); tick(); tick();
        checks++;
        if (obs() != "M") begin
            errors++; $display("FAIL rst_setup: got %s want M", obs());
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || obs() != "I" || stat !== 3'd1 || instr_count !== '0) begin
            errors++; $display("FAIL rst_mid_mem: got mem_req=%0b %s stat=%0d", mem_req, obs(), stat);
        end
    endtask

    task automatic test_random();
        logic [3:0] ic;
        do_reset(); do_start();
        for (int n = 0; n < 22; n++) begin
            ic = 4'($urandom_range(1, 11));
            run_instr(ic, 1'b1, 1'b0, int'($urandom_range(1, 6)), 1'b0);
        end
        checks++;
        if (instr_count !== CNT_W'(CNT_MAX)) begin
            errors++; $display("FAIL count_saturate: got %0d want %0d", instr_count, CNT_MAX);
        end
        run_instr(4'hB, 1'b1, 1'b0, int'($urandom_range(1, 6)), 1'b1);
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_mem_ack3();
        test_timeout();
        test_faults();
        test_halt();
        test_rst_mid_mem();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
